adap_quan_sched: RTL and testbench

Round-robin scheduler that time-shares one adaptive quantizer (LOG → SUBTB → QUAN, combinational) among NCH ADPCM channel requesters in the multi-channel codec. Each channel presents its difference signal D, scale factor Y and RATE with a request. The scheduler grants one channel, registers its operands onto the quantizer inputs, and holds them for LAT cycles. It then captures the 5-bit code I and returns it tagged with the channel number.

---
 rtl/adap_quan_sched.sv | 138 +++++++++++++
 tb/tb_adap_quan_sched.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adap_quan_sched.sv
// Round-robin scheduler sharing one combinational adaptive quantizer among NCH channels.
// Optional `ADQ_SCHED_PRIO0_EN gives channel 0 fixed priority over the round-robin pool.
`timescale 1ns/1ps
module adap_quan_sched #(
  parameter  int unsigned CHW = 2,
  parameter  int unsigned LAT = 1,
  localparam int unsigned NCH = 2 ** CHW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req,
  input  logic [16*NCH-1:0] d_in,
  input  logic [13*NCH-1:0] y_in,
  input  logic [2*NCH-1:0]  rate_in,
  output logic [NCH-1:0]    gnt,
  output logic [15:0]       q_d,
  output logic [12:0]       q_y,
  output logic [1:0]        q_rate,
  input  logic [4:0]        q_i,
  output logic [4:0]        i_out,
  output logic [CHW-1:0]    i_ch,
  output logic              i_valid,
  output logic              busy
);

  localparam int unsigned CW = 3;
`ifdef ADQ_SCHED_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_q, state_d;
  logic [CHW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NCH-1:0] gnt_d;
  logic [15:0]    q_d_d;
  logic [12:0]    q_y_d;
  logic [1:0]     q_rate_d;
  logic [4:0]     i_out_d;
  logic [CHW-1:0] i_ch_d;
  logic           i_valid_d;
  logic           busy_d;

  logic           found;
  logic [CHW-1:0] win;
  logic [CHW-1:0] idx;

  // Winner search: first requester at or after ptr, channel 0 pre-empting when prioritised
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    if (PRIO0 && req[0]) begin
      found = 1'b1;
    end
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = CHW'(32'(ptr_q) + k);
      if (!found && req[idx] && !(PRIO0 && idx == '0)) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    q_d_d     = q_d;
    q_y_d     = q_y;
    q_rate_d  = q_rate;
    i_out_d   = i_out;
    i_ch_d    = i_ch;
    i_valid_d = 1'b0;
    busy_d    = busy;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d    = NCH'(1) << win;
          q_d_d    = d_in[32'(win)*16 +: 16];
          q_y_d    = y_in[32'(win)*13 +: 13];
          q_rate_d = rate_in[32'(win)*2 +: 2];
          i_ch_d   = win;
          if (!(PRIO0 && win == '0)) begin
            ptr_d = win + CHW'(1);
          end
          cnt_d    = CW'(LAT - 1);
          busy_d   = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          i_out_d   = q_i;
          i_valid_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt     <= '0;
      q_d     <= '0;
      q_y     <= '0;
      q_rate  <= '0;
      i_out   <= '0;
      i_ch    <= '0;
      i_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt     <= gnt_d;
      q_d     <= q_d_d;
      q_y     <= q_y_d;
      q_rate  <= q_rate_d;
      i_out   <= i_out_d;
      i_ch    <= i_ch_d;
      i_valid <= i_valid_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_adap_quan_sched.sv
// Bench for adap_quan_sched: two instances (LAT=1, LAT=3) share stimulus and are
// checked against a transaction-timed reference model plus directed sequences.
`timescale 1ns/1ps
module tb_adap_quan_sched;

  localparam int NCH = 4;
`ifdef ADQ_SCHED_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  gnt;
    logic [15:0] qd;
    logic [12:0] qy;
    logic [1:0]  qr;
    logic [4:0]  iout;
    logic [1:0]  ich;
    logic        ival;
    logic        busy;
  } obs_t;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] d;
    logic [12:0] y;
    logic [1:0]  r;
    logic [3:0]  exp_gnt;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] d_in;
  logic [51:0] y_in;
  logic [7:0]  rate_in;

  logic [3:0]  gnt_o  [2];
  logic [15:0] qd_o   [2];
  logic [12:0] qy_o   [2];
  logic [1:0]  qr_o   [2];
  logic [4:0]  qi     [2];
  logic [4:0]  iout_o [2];
  logic [1:0]  ich_o  [2];
  logic        ival_o [2];
  logic        busy_o [2];

  int   n_pass  = 0;
  int   n_total = 0;
  bit   chk_en  = 1'b0;
  int   cyc     = 0;
  obs_t e      [2];
  int   m_free [2];
  int   m_done [2];
  int   m_ptr  [2];
  logic [4:0] m_pend [2];

  // Stand-in quantizer: any fixed function of the operands will do
  function automatic logic [4:0] qfun(input logic [15:0] d, input logic [12:0] y,
                                      input logic [1:0] r);
    return d[4:0] ^ d[15:11] ^ y[12:8] ^ (y[4:0] + {3'b000, r});
  endfunction

  adap_quan_sched #(.CHW(2), .LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req), .d_in(d_in), .y_in(y_in), .rate_in(rate_in),
    .gnt(gnt_o[0]), .q_d(qd_o[0]), .q_y(qy_o[0]), .q_rate(qr_o[0]), .q_i(qi[0]),
    .i_out(iout_o[0]), .i_ch(ich_o[0]), .i_valid(ival_o[0]), .busy(busy_o[0])
  );

  adap_quan_sched #(.CHW(2), .LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .req(req), .d_in(d_in), .y_in(y_in), .rate_in(rate_in),
    .gnt(gnt_o[1]), .q_d(qd_o[1]), .q_y(qy_o[1]), .q_rate(qr_o[1]), .q_i(qi[1]),
    .i_out(iout_o[1]), .i_ch(ich_o[1]), .i_valid(ival_o[1]), .busy(busy_o[1])
  );

  assign qi[0] = qfun(qd_o[0], qy_o[0], qr_o[0]);
  assign qi[1] = qfun(qd_o[1], qy_o[1], qr_o[1]);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  function automatic obs_t obs(input int u);
    obs_t o;
    o.gnt  = gnt_o[u];
    o.qd   = qd_o[u];
    o.qy   = qy_o[u];
    o.qr   = qr_o[u];
    o.iout = iout_o[u];
    o.ich  = ich_o[u];
    o.ival = ival_o[u];
    o.busy = busy_o[u];
    return o;
  endfunction

  function automatic int pick(input logic [3:0] r, input int p);
    if (PRIO0 && r[0]) return 0;
    for (int k = 0; k < NCH; k++) begin
      int idx = (p + k) % NCH;
      if (r[idx] && !(PRIO0 && idx == 0)) return idx;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
  endtask

  // Reference model: a grant decided in an idle cycle c shows at c+1; the result
  // shows at c+1+LAT, which is also the first cycle a new grant can be decided.
  task automatic model_step();
    int w;
    for (int u = 0; u < 2; u++) begin
      if (reset) begin
        e[u]      = '0;
        m_free[u] = cyc + 1;
        m_done[u] = -1;
        m_ptr[u]  = 0;
      end else begin
        e[u].gnt  = 4'b0000;
        e[u].ival = (cyc + 1 == m_done[u]);
        if (e[u].ival) e[u].iout = m_pend[u];
        if (cyc >= m_free[u] && req != 4'b0000) begin
          w = pick(req, m_ptr[u]);
          e[u].gnt  = 4'(1 << w);
          e[u].qd   = d_in[16*w +: 16];
          e[u].qy   = y_in[13*w +: 13];
          e[u].qr   = rate_in[2*w +: 2];
          e[u].ich  = 2'(w);
          m_pend[u] = qfun(e[u].qd, e[u].qy, e[u].qr);
          m_free[u] = cyc + 1 + lat_of(u);
          m_done[u] = m_free[u];
          if (!(PRIO0 && w == 0)) m_ptr[u] = (w + 1) % NCH;
        end
        e[u].busy = (cyc + 1 < m_free[u]);
      end
    end
    cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int u = 0; u < 2; u++) check($sformatf("model_du%0d", u), 64'(obs(u)), 64'(e[u]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    step();
    reset = 1'b0;
  endtask

  vec_t tbl [4];

  initial begin
    tbl[0] = '{2'd2, 16'h0123, 13'h0880, 2'b01, 4'b0100};
    tbl[1] = '{2'd0, 16'hFFFF, 13'h1FFF, 2'b11, 4'b0001};
    tbl[2] = '{2'd3, 16'h8000, 13'h0000, 2'b10, 4'b1000};
    tbl[3] = '{2'd1, 16'h0000, 13'h0001, 2'b00, 4'b0010};

    reset   = 1'b1;
    req     = 4'b0000;
    d_in    = '0;
    y_in    = '0;
    rate_in = '0;
    step();
    step();
    reset  = 1'b0;
    chk_en = 1'b1;

    // Reset then idle
    for (int j = 0; j < 10; j++) begin
      step();
      check("idle_du0", 64'(obs(0)), 64'(0));
      check("idle_du1", 64'(obs(1)), 64'(0));
    end

    // Single-channel vectors on the LAT=1 instance
    for (int i = 0; i < 4; i++) begin
      req = 4'b0000;
      repeat (4) step();
      d_in    = {$urandom, $urandom};
      y_in    = 52'({$urandom, $urandom});
      rate_in = 8'($urandom);
      d_in[16*tbl[i].ch +: 16]   = tbl[i].d;
      y_in[13*tbl[i].ch +: 13]   = tbl[i].y;
      rate_in[2*tbl[i].ch +: 2]  = tbl[i].r;
      req = 4'(1 << tbl[i].ch);
      step();
      req = 4'b0000;
      check("vec_gnt",   64'(gnt_o[0]),  64'(tbl[i].exp_gnt));
      check("vec_q_d",   64'(qd_o[0]),   64'(tbl[i].d));
      check("vec_q_y",   64'(qy_o[0]),   64'(tbl[i].y));
      check("vec_q_rate",64'(qr_o[0]),   64'(tbl[i].r));
      check("vec_busy",  64'(busy_o[0]), 64'(1));
      step();
      check("vec_valid", 64'(ival_o[0]), 64'(1));
      check("vec_ich",   64'(ich_o[0]),  64'(tbl[i].ch));
      check("vec_iout",  64'(iout_o[0]), 64'(qfun(tbl[i].d, tbl[i].y, tbl[i].r)));
      check("vec_idle",  64'(busy_o[0]), 64'(0));
    end

    // Fairness with all requests held (channel 0 pinned when prioritised)
    do_reset();
    req = PRIO0 ? 4'b1011 : 4'b1111;
    for (int j = 0; j < 10; j++) begin
      step();
      check("rr_gnt", 64'(gnt_o[0]),
            (j % 2 == 0) ? 64'(PRIO0 ? 4'b0001 : 4'(1 << ((j / 2) % 4))) : 64'(0));
      check("rr_valid", 64'(ival_o[0]), 64'(j % 2));
      if (j % 2 == 1) check("rr_ich", 64'(ich_o[0]), 64'(PRIO0 ? 0 : ((j - 1) / 2) % 4));
    end
    req = 4'b0000;

    // Wrap and skip: ptr at 3 after ch2
    do_reset();
    req = 4'b0100;
    step();
    req = 4'b0000;
    check("wrap_g2", 64'(gnt_o[0]), 64'(4'b0100));
    step();
    req = 4'b0011;
    step();
    req = 4'b0000;
    check("wrap_g0", 64'(gnt_o[0]), 64'(4'b0001));
    step();
    req = 4'b0010;
    step();
    req = 4'b0000;
    check("wrap_g1", 64'(gnt_o[0]), 64'(4'b0010));

    // LAT=3 timing with a second request arriving mid-operation
    repeat (4) step();
    do_reset();
    req = 4'b0001;
    step();
    req = 4'b0000;
    check("l3_gnt1",  64'(gnt_o[1]),  64'(4'b0001));
    check("l3_busy1", 64'(busy_o[1]), 64'(1));
    check("l3_val1",  64'(ival_o[1]), 64'(0));
    step();
    req = 4'b0010;
    check("l3_busy2", 64'(busy_o[1]), 64'(1));
    check("l3_val2",  64'(ival_o[1]), 64'(0));
    step();
    check("l3_busy3", 64'(busy_o[1]), 64'(1));
    check("l3_val3",  64'(ival_o[1]), 64'(0));
    step();
    check("l3_val4",  64'(ival_o[1]), 64'(1));
    check("l3_busy4", 64'(busy_o[1]), 64'(0));
    check("l3_ich4",  64'(ich_o[1]),  64'(0));
    step();
    req = 4'b0000;
    check("l3_gnt5",  64'(gnt_o[1]),  64'(4'b0010));

    // Reset in the middle of a LAT=3 operation
    repeat (5) step();
    do_reset();
    req = 4'b0001;
    step();
    req   = 4'b0000;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int j = 0; j < 5; j++) begin
      check("midrst", 64'(obs(1)), 64'(0));
      step();
    end

    // Randomized traffic, checked by the model every cycle
    for (int j = 0; j < 1500; j++) begin
      reset   = ($urandom_range(0, 149) == 0);
      req     = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      d_in    = {$urandom, $urandom};
      y_in    = 52'({$urandom, $urandom});
      rate_in = 8'($urandom);
      step();
    end
    reset = 1'b0;
    req   = 4'b0000;
    repeat (6) step();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
